// File: rtl/ff_pattern_checker.sv
// Drives a pattern sequence on cs and compares the returned ns against a delayed
// copy of the drive to verify a LATENCY-stage register pipeline.
module ff_pattern_checker #(
  parameter int LATENCY = 2,
  parameter int NVEC    = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [3:0] ns,
  output logic [3:0] cs,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       first_err_valid,
  output logic [7:0] first_err_vec
);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} state_t;

  localparam logic [8:0] PRIME_LAST = 9'(LATENCY - 1);
  localparam logic [8:0] VEC_LAST   = 9'(NVEC - 1);
  localparam logic [8:0] DRAIN_LAST = 9'(NVEC + LATENCY - 1);
  localparam logic [8:0] LAT        = 9'(LATENCY);
  localparam bit         SKIP_RUN   = (NVEC <= LATENCY);

  state_t     state, state_nx;
  logic [8:0] cyc;
  logic [1:0] mode_q;
  logic       verdict_q;
  logic [3:0] exp_dly [LATENCY];
  logic       accept;
  logic       cmp_en;
  logic       mismatch;

  function automatic logic [3:0] first_vec(input logic [1:0] m);
    logic [3:0] v;
    case (m)
      2'd1, 2'd2: v = 4'b0001;
      default:    v = 4'b0000;
    endcase
    first_vec = v;
  endfunction

  // Each pattern is generated incrementally from the vector currently on cs.
  function automatic logic [3:0] next_vec(input logic [1:0] m, input logic [3:0] v);
    logic [3:0] n;
    case (m)
      2'd0:    n = v + 4'd1;
      2'd1:    n = {v[2:0], v[3]};
      2'd2:    n = {v[2:0], v[3] ^ v[2]};
      default: n = ~v;
    endcase
    next_vec = n;
  endfunction

  assign accept   = (state == IDLE) && start;
  assign busy     = (state == PRIME) || (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign pass     = (done || verdict_q) && (err_count == 8'd0);
  assign cmp_en   = (state == RUN) || (state == DRAIN);
  assign mismatch = cmp_en && (ns != exp_dly[LATENCY-1]);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PRIME;
      PRIME:   if (cyc == PRIME_LAST) state_nx = SKIP_RUN ? DRAIN : RUN;
      RUN:     if (cyc == VEC_LAST) state_nx = DRAIN;
      DRAIN:   if (cyc == DRAIN_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cyc             <= '0;
      mode_q          <= '0;
      cs              <= '0;
      verdict_q       <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      for (int i = 0; i < LATENCY; i++) exp_dly[i] <= '0;
    end else begin
      state      <= state_nx;
      exp_dly[0] <= cs;
      for (int i = 1; i < LATENCY; i++) exp_dly[i] <= exp_dly[i-1];
      if (accept) begin
        cyc             <= '0;
        mode_q          <= mode;
        cs              <= first_vec(mode);
        verdict_q       <= 1'b0;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_vec   <= '0;
      end else begin
        if (busy) cyc <= cyc + 9'd1;
        // cs carries vector cyc+1 into the next cycle, zero once the run is exhausted
        cs <= (busy && (cyc < VEC_LAST)) ? next_vec(mode_q, cs) : 4'b0000;
        if (mismatch) begin
          err_count <= err_count + 8'd1;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_vec   <= 8'(cyc - LAT);
          end
        end
        if (state == DONE) verdict_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ff_pattern_checker.sv
// Bench for ff_pattern_checker: a configurable external pipeline with fault
// injection, checked against a vector-list reference model.
module tb_ff_pattern_checker;
  localparam int LAT  = 2;
  localparam int NV   = 16;
  localparam int LAT2 = 3;
  localparam int NV2  = 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start, start2;
  logic [1:0] mode, mode2;
  logic [3:0] ns, ns2, cs, cs2;
  logic       busy, done, pass, fev;
  logic [7:0] ec, fvec;
  logic       busy2, done2, pass2, fev2;
  logic [7:0] ec2, fvec2;
  logic [3:0] ch0, ch1, c2a, c2b, c2c;
  int         tap;
  logic [3:0] amask, xmask, amask2;
  int         tests = 0;
  int         fails = 0;

  ff_pattern_checker #(.LATENCY(LAT), .NVEC(NV)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode), .ns(ns), .cs(cs),
    .busy(busy), .done(done), .pass(pass), .err_count(ec),
    .first_err_valid(fev), .first_err_vec(fvec)
  );

  ff_pattern_checker #(.LATENCY(LAT2), .NVEC(NV2)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .mode(mode2), .ns(ns2), .cs(cs2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(ec2),
    .first_err_valid(fev2), .first_err_vec(fvec2)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    ch0 <= cs;
    ch1 <= ch0;
    c2a <= cs2;
    c2b <= c2a;
    c2c <= c2b;
  end

  assign ns  = (((tap == 1) ? ch0 : ch1) & amask) ^ xmask;
  assign ns2 = c2c & amask2;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] vec_of(input int md, input int k);
    logic [3:0] v;
    case (md)
      0: v = 4'(k % 16);
      1: v = 4'(1 << (k % 4));
      2: begin
        v = 4'b0001;
        for (int i = 0; i < (k % 15); i++) v = {v[2:0], v[3] ^ v[2]};
      end
      default: v = ((k % 2) == 1) ? 4'hF : 4'h0;
    endcase
    return v;
  endfunction

  task automatic run1(input int md, input int tp, input logic [3:0] am,
                      input int flip_pct, input bit hold);
    logic [3:0] vec [NV];
    logic [3:0] xm [NV+LAT];
    bit         mis [NV];
    int         exp_err, exp_first, so_far, idx;
    logic [3:0] src, cs_exp;
    tap = tp; amask = am; xmask = 4'h0;
    for (int k = 0; k < NV; k++) vec[k] = vec_of(md, k);
    for (int c = 0; c < NV + LAT; c++)
      xm[c] = ($urandom_range(99) < flip_pct) ? 4'($urandom_range(15)) : 4'h0;
    exp_err = 0; exp_first = 0;
    for (int k = 0; k < NV; k++) begin
      idx = k + LAT - tp;
      src = (idx < NV) ? vec[idx] : 4'h0;
      mis[k] = (((src & am) ^ xm[k+LAT]) != vec[k]);
      if (mis[k]) begin
        if (exp_err == 0) exp_first = k;
        exp_err++;
      end
    end
    mode = 2'(md); start = 1'b1;
    @(posedge clock); #1;
    for (int c = 0; c <= NV + LAT; c++) begin
      start = hold ? 1'b1 : 1'($urandom_range(1));
      mode  = 2'($urandom_range(3));
      xmask = (c < NV + LAT) ? xm[c] : 4'h0;
      @(negedge clock);
      cs_exp = (c < NV) ? vec[c] : 4'h0;
      so_far = 0;
      for (int k = 0; k < NV; k++) if (mis[k] && (k + LAT < c)) so_far++;
      if (c < NV + LAT) begin
        chk($sformatf("busy m%0d c%0d", md, c), 32'(busy), 1);
        chk($sformatf("done m%0d c%0d", md, c), 32'(done), 0);
        chk($sformatf("pass m%0d c%0d", md, c), 32'(pass), 0);
        chk($sformatf("cs m%0d c%0d", md, c), 32'(cs), 32'(cs_exp));
        chk($sformatf("errcnt m%0d c%0d", md, c), 32'(ec), so_far);
        chk($sformatf("fev m%0d c%0d", md, c), 32'(fev), (so_far > 0) ? 1 : 0);
      end else begin
        chk("done pulse", 32'(done), 1);
        chk("busy at done", 32'(busy), 0);
        chk("cs at done", 32'(cs), 0);
        chk("pass at done", 32'(pass), (exp_err == 0) ? 1 : 0);
        chk("errcnt at done", 32'(ec), exp_err);
        chk("fev at done", 32'(fev), (exp_err > 0) ? 1 : 0);
        chk("fvec at done", 32'(fvec), exp_first);
      end
      @(posedge clock); #1;
    end
    xmask = 4'h0; start = hold;
    @(negedge clock);
    chk("done after", 32'(done), 0);
    chk("busy after", 32'(busy), 0);
    chk("pass held", 32'(pass), (exp_err == 0) ? 1 : 0);
    chk("errcnt held", 32'(ec), exp_err);
    chk("fev held", 32'(fev), (exp_err > 0) ? 1 : 0);
    chk("fvec held", 32'(fvec), exp_first);
  endtask

  task automatic run2(input int md, input logic [3:0] am);
    logic [3:0] vec [NV2];
    int         exp_err, exp_first;
    exp_err = 0; exp_first = 0;
    for (int k = 0; k < NV2; k++) begin
      vec[k] = vec_of(md, k);
      if ((vec[k] & am) != vec[k]) begin
        if (exp_err == 0) exp_first = k;
        exp_err++;
      end
    end
    mode2 = 2'(md); amask2 = am; start2 = 1'b1;
    @(posedge clock); #1;
    start2 = 1'b0;
    for (int c = 0; c <= NV2 + LAT2; c++) begin
      @(negedge clock);
      if (c < NV2 + LAT2) begin
        chk($sformatf("short busy c%0d", c), 32'(busy2), 1);
        chk($sformatf("short done c%0d", c), 32'(done2), 0);
        chk($sformatf("short cs c%0d", c), 32'(cs2), (c < NV2) ? 32'(vec[c]) : 0);
      end else begin
        chk("short done pulse", 32'(done2), 1);
        chk("short pass", 32'(pass2), (exp_err == 0) ? 1 : 0);
        chk("short errcnt", 32'(ec2), exp_err);
        chk("short fvec", 32'(fvec2), exp_first);
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset_n = 1'b1; start = 1'b0; start2 = 1'b0; mode = 2'd0; mode2 = 2'd0;
    tap = 2; amask = 4'hF; xmask = 4'h0; amask2 = 4'hF;
    #1 reset_n = 1'b0;
    #2;
    chk("rst cs", 32'(cs), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst pass", 32'(pass), 0);
    chk("rst errcnt", 32'(ec), 0);
    chk("rst fev", 32'(fev), 0);
    chk("rst fvec", 32'(fvec), 0);
    chk("rst short busy", 32'(busy2), 0);
    #20 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    run1(0, 2, 4'hF, 0, 1'b0);
    chk("loopback pass", 32'(pass), 1);
    chk("loopback errcnt", 32'(ec), 0);
    @(posedge clock); #1;
    run1(1, 2, 4'b1011, 0, 1'b0);
    chk("stuck ns2 errcnt", 32'(ec), 4);
    chk("stuck ns2 fvec", 32'(fvec), 2);
    @(posedge clock); #1;
    run1(0, 1, 4'hF, 0, 1'b0);
    chk("short pipe errcnt", 32'(ec), 16);
    chk("short pipe fvec", 32'(fvec), 0);
    @(posedge clock); #1;
    run1(3, 2, 4'h0, 0, 1'b0);
    chk("ns zero errcnt", 32'(ec), 8);
    chk("ns zero fvec", 32'(fvec), 1);
    @(posedge clock); #1;

    for (int r = 0; r < 6; r++) begin
      run1(int'($urandom_range(3)), int'($urandom_range(2, 1)),
           ($urandom_range(1) == 1) ? 4'hF : 4'($urandom_range(15)),
           int'($urandom_range(30)), 1'b0);
      @(posedge clock); #1;
    end

    // start held through a whole run, then a reset aborts the follow-on run
    run1(2, 2, 4'hF, 0, 1'b1);
    mode = 2'd1; amask = 4'h0; tap = 2;
    @(posedge clock); #1;
    chk("restart busy", 32'(busy), 1);
    chk("restart cs", 32'(cs), 32'(4'b0001));
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("abort pre errcnt", 32'(ec), 3);
    reset_n = 1'b0;
    #1;
    chk("abort cs", 32'(cs), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort errcnt", 32'(ec), 0);
    chk("abort fev", 32'(fev), 0);
    chk("abort fvec", 32'(fvec), 0);
    #2 reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk($sformatf("no done after abort c%0d", c), 32'(done), 0);
      chk($sformatf("idle after abort c%0d", c), 32'(busy), 0);
    end
    amask = 4'hF;
    @(posedge clock); #1;
    run1(2, 2, 4'hF, 0, 1'b0);
    chk("post reset pass", 32'(pass), 1);
    @(posedge clock); #1;

    run2(1, 4'hF);
    run2(2, 4'b1110);
    run2(3, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
